instr_fetch: RTL and testbench

- Fetch stage directly upstream of instruction decode and immediate extension.
- Owns the program counter and issues word-aligned requests to instruction memory over a valid/ready handshake.
- Buffers in-order responses with their PC and presents {pc, instr} to decode over a valid/ready handshake.
- Handles redirects from branch/jump resolution by flushing buffered and in-flight instructions.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 53 +++++
 rtl/instr_fetch.sv | 131 +++++++++++++
 tb/tb_instr_fetch.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    DRAIN
  } fetch_state_e;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; used for the instruction buffer and the in-flight PC queue.
module fetch_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [31:0]
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  T                       wdata,
  input  logic                   pop,
  input  logic                   flush,
  output T                       rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: the storage array is deliberately left out of reset; only the
  // pointers and count define what is valid, so the array can map to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values
  // and the pointer/count updates cannot race each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues credit-limited imem requests, buffers
// in-order responses for decode and flushes on redirect.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  state;
  logic [31:0]   pc;
  logic [31:0]   last_pc;
  logic [31:0]   redirect_target;
  logic [31:0]   pcq_head;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [CW-1:0] pcq_count;
  logic [CW-1:0] out_after_rsp;
  logic [CW:0]   credit_used;
  logic          redirect;
  logic          req_fire;
  logic          rsp_ok;
  logic          rsp_keep;
  logic          dec_fire;
  fetch_entry_t  ibuf_head;
  fetch_entry_t  ibuf_wdata;

  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign redirect        = redirect_valid && (state != BOOT);
  assign credit_used     = {1'b0, outstanding} + {1'b0, count};

  assign imem_req_valid  = (state == FETCH) && (credit_used < (CW+1)'(DEPTH)) && !redirect_valid;
  assign imem_req_addr   = pc;
  assign req_fire        = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is dropped.
  assign rsp_ok          = imem_rsp_valid && (outstanding != '0);
  assign rsp_keep        = rsp_ok && (state == FETCH) && !redirect;
  assign out_after_rsp   = outstanding - CW'(rsp_ok);

  assign dec_valid       = (count != '0);
  assign dec_fire        = dec_valid && dec_ready;
  assign dec_instr       = dec_valid ? ibuf_head.instr : INSTR_NOP;
  assign dec_pc          = dec_valid ? ibuf_head.pc : last_pc;
  assign ibuf_wdata      = '{pc: pcq_head, instr: imem_rsp_data};

  fetch_fifo #(.DEPTH(DEPTH), .T(logic [31:0])) u_pc_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_fire),
    .wdata (pc),
    .pop   (rsp_keep),
    .flush (redirect),
    .rdata (pcq_head),
    .count (pcq_count)
  );

  fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_ibuf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_keep),
    .wdata (ibuf_wdata),
    .pop   (dec_fire),
    .flush (redirect),
    .rdata (ibuf_head),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      last_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      if (dec_valid) last_pc <= ibuf_head.pc;
      case (state)
        BOOT: begin
          state <= FETCH;
          if (redirect_valid) pc <= redirect_target;
        end
        FETCH, DRAIN: begin
          if (redirect) begin
            // Everything still in flight becomes stale; drain it before refetching.
            pc          <= redirect_target;
            outstanding <= out_after_rsp;
            drop        <= out_after_rsp;
            state       <= (out_after_rsp != '0) ? DRAIN : FETCH;
          end else if (state == FETCH) begin
            if (req_fire) pc <= pc + 32'd4;
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_ok);
          end else if (rsp_ok) begin
            drop        <= drop - CW'(1);
            outstanding <= outstanding - CW'(1);
            if (drop == CW'(1)) state <= FETCH;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  a_no_stray_rsp : assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rsp_valid && (outstanding == '0)))
    else $warning("instr_fetch: imem response with no request outstanding, ignored");

  a_credit : assert property (@(posedge clk) disable iff (!rst_n)
    credit_used <= (CW+1)'(DEPTH));

  a_pcq_tracks : assert property (@(posedge clk) disable iff (!rst_n)
    (state != FETCH) || (pcq_count == outstanding));

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed stimulus, in-order memory model,
// negedge monitor comparing request addresses and decode handoffs.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;

  int          n_chk;
  int          n_pass;
  int          req_cnt;
  int          dec_cnt;
  int          req_base;
  int          cyc;
  int          lat;
  bit          inject;

  logic [31:0] exp_req[$];
  logic [31:0] exp_dec[$];
  rsp_t        pending[$];

  instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
  endtask

  // Memory model: in-order, fixed latency; the word returned is ~addr.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (!rst_n) begin
        pending.delete();
        imem_rsp_valid = 1'b0;
      end else if (pending.size() != 0 && pending[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = pending[0].data;
        void'(pending.pop_front());
      end else if (inject) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end
    end
  end

  // Monitor: compares every request and decode handshake against the queues.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (imem_req_valid && imem_req_ready) begin
          req_cnt++;
          if (exp_req.size() == 0) begin
            n_chk++;
            $display("FAIL req_extra: got request at %08h, expected none", imem_req_addr);
          end else begin
            e = exp_req.pop_front();
            check("req_addr", imem_req_addr, e);
          end
          pending.push_back('{due: cyc + lat, data: ~imem_req_addr});
        end
        if (dec_valid && dec_ready) begin
          dec_cnt++;
          if (exp_dec.size() == 0) begin
            n_chk++;
            $display("FAIL dec_extra: got dec_pc %08h, expected no instruction", dec_pc);
          end else begin
            e = exp_dec.pop_front();
            check("dec_pc", dec_pc, e);
            check("dec_instr", dec_instr, ~e);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_fetch(input logic [31:0] a, input bit to_dec);
    exp_req.push_back(a);
    if (to_dec) exp_dec.push_back(a);
  endtask

  // Leaves the bench in cycle 1 (BOOT) with reset released.
  task automatic do_reset(input int latency, input logic rdy);
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    dec_ready      = rdy;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inject         = 1'b0;
    lat            = latency;
    tick(2);
    rst_n    = 1'b1;
    req_base = req_cnt;
  endtask

  task automatic wait_reqs(input int n);
    int budget = 200;
    tick();
    while (req_cnt - req_base < n && budget > 0) begin
      tick();
      budget--;
    end
    check("req_count", 32'(req_cnt - req_base), 32'(n));
    imem_req_ready = 1'b0;
  endtask

  task automatic wait_drain();
    int budget = 200;
    while ((exp_dec.size() != 0 || exp_req.size() != 0) && budget > 0) begin
      tick();
      budget--;
    end
    check("dec_left", 32'(exp_dec.size()), 32'd0);
    check("req_left", 32'(exp_req.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    check({tag, "_req_addr"},  imem_req_addr,        32'h0);
    check({tag, "_dec_valid"}, 32'(dec_valid),       32'd0);
    check({tag, "_dec_instr"}, dec_instr,            NOP);
    check({tag, "_dec_pc"},    dec_pc,               32'h0);
  endtask

  initial begin
    int d0;
    n_chk = 0; n_pass = 0; req_cnt = 0; dec_cnt = 0; cyc = 0; lat = 1; inject = 1'b0;
    imem_req_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; dec_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("reset");

    // Streaming, 1-cycle latency: credit loop is 3 cycles for 2 entries.
    do_reset(1, 1'b1);
    for (int i = 0; i < 8; i++) expect_fetch(32'(i * 4), 1'b1);
    @(negedge clk);
    check("boot_no_req", 32'(imem_req_valid), 32'd0);
    tick();
    @(negedge clk);
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr", imem_req_addr, 32'h0);
    tick();
    d0 = dec_cnt;
    tick(6);
    check("dec_per_6_cycles", 32'(dec_cnt - d0), 32'd4);
    wait_reqs(8);
    wait_drain();

    // Decode stalled: only DEPTH requests, then resume at 0x8.
    do_reset(1, 1'b0);
    expect_fetch(32'h0, 1'b1); expect_fetch(32'h4, 1'b1); expect_fetch(32'h8, 1'b1);
    tick(8);
    @(negedge clk);
    check("stall_req_count", 32'(req_cnt - req_base), 32'd2);
    check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check("stall_req_addr", imem_req_addr, 32'h8);
    check("stall_dec_valid", 32'(dec_valid), 32'd1);
    check("stall_dec_pc", dec_pc, 32'h0);
    tick();
    dec_ready = 1'b1;
    wait_reqs(3);
    wait_drain();

    // Redirect with two requests in flight, 3-cycle latency.
    do_reset(3, 1'b1);
    expect_fetch(32'h0, 1'b0); expect_fetch(32'h4, 1'b0); expect_fetch(32'h100, 1'b1);
    tick(3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    @(negedge clk);
    check("redir_no_req", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("drain1_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    @(negedge clk);
    check("drain2_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    @(negedge clk);
    check("refetch_req_valid", 32'(imem_req_valid), 32'd1);
    check("refetch_req_addr", imem_req_addr, 32'h100);
    wait_reqs(3);
    wait_drain();

    // Redirect coinciding with a response and a decode pop.
    do_reset(1, 1'b1);
    expect_fetch(32'h0, 1'b1); expect_fetch(32'h4, 1'b1);
    expect_fetch(32'h8, 1'b1); expect_fetch(32'hC, 1'b0);
    expect_fetch(32'h200, 1'b1);
    tick(6);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    @(negedge clk);
    check("coinc_rsp_present", 32'(imem_rsp_valid), 32'd1);
    check("coinc_dec_pc", dec_pc, 32'h8);
    check("coinc_no_req", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("after_redir_dec_valid", 32'(dec_valid), 32'd0);
    check("after_redir_dec_instr", dec_instr, NOP);
    check("after_redir_dec_pc_held", dec_pc, 32'h8);
    check("after_redir_req_addr", imem_req_addr, 32'h200);
    check("after_redir_req_valid", 32'(imem_req_valid), 32'd1);
    wait_reqs(5);
    wait_drain();

    // Stray response with nothing outstanding must be ignored.
    do_reset(1, 1'b0);
    expect_fetch(32'h0, 1'b1);
    wait_reqs(1);
    tick(2);
    inject = 1'b1;
    tick();
    inject = 1'b0;
    tick();
    @(negedge clk);
    check("stray_dec_valid", 32'(dec_valid), 32'd1);
    check("stray_dec_pc", dec_pc, 32'h0);
    check("stray_dec_instr", dec_instr, 32'hFFFF_FFFF);
    check("stray_req_valid", 32'(imem_req_valid), 32'd1);
    check("stray_req_addr", imem_req_addr, 32'h4);
    tick();
    dec_ready = 1'b1;
    tick();
    @(negedge clk);
    check("stray_not_buffered", 32'(dec_valid), 32'd0);
    check("stray_credit_intact", 32'(imem_req_valid), 32'd1);
    wait_drain();

    // Redirect during BOOT to the top word; PC wraps to 0.
    do_reset(1, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    expect_fetch(32'hFFFF_FFFC, 1'b1); expect_fetch(32'h0, 1'b1);
    @(negedge clk);
    check("boot_redir_no_req", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("wrap_first_valid", 32'(imem_req_valid), 32'd1);
    check("wrap_first_addr", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    @(negedge clk);
    check("wrap_next_addr", imem_req_addr, 32'h0);
    wait_reqs(2);
    wait_drain();

    // Asynchronous reset in the middle of DRAIN.
    do_reset(3, 1'b1);
    expect_fetch(32'h0, 1'b0); expect_fetch(32'h4, 1'b0);
    tick(3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("drain_req_addr", imem_req_addr, 32'h40);
    check("drain_req_valid", 32'(imem_req_valid), 32'd0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async");
    imem_req_ready = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    @(negedge clk);
    check("post_reset_req_valid", 32'(imem_req_valid), 32'd1);
    check("post_reset_req_addr", imem_req_addr, 32'h0);
    check("post_reset_req_left", 32'(exp_req.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
